// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter_pkg
// Brief    : Shared types and constants for the two-port SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_port_arbiter_pkg;

    // Access sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WHOLD = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Port indices: instruction fetch and data
    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    // Pin values while no access is in progress
    localparam logic       c_IDLE_CE_N = 1'b1;
    localparam logic       c_IDLE_OE_N = 1'b1;
    localparam logic       c_IDLE_WE_N = 1'b1;
    localparam logic [3:0] c_IDLE_BE_N = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/sram_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_seq
// Brief    : READ/WRITE/WHOLD/DONE timing FSM, SRAM pin decode and data
//            tristate for one asynchronous SRAM chip.
// Revision : 1.0 - initial release
// ============================================================================
module sram_access_seq
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 20,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_capture,
    output logic [31:0]           o_rdata,
    inout  wire  [31:0]           io_ram_data,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [3:0]            o_ram_be_n,
    output logic                  o_ram_ce_n,
    output logic                  o_ram_oe_n,
    output logic                  o_ram_we_n
);

    localparam int c_MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_READ_LOAD  = c_CNT_W'(READ_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WRITE_LOAD = c_CNT_W'(WRITE_CYCLES - 1);

    seq_state_e         r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic               w_drive;

    // Next state: counter is loaded on entry and counts down to 0, never wraps
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_d = i_we ? ST_WRITE : ST_READ;
                    w_cnt_d   = i_we ? c_WRITE_LOAD : c_READ_LOAD;
                end
            end
            ST_READ: begin
                if (r_cnt_q == '0) w_state_d = ST_DONE;
                else               w_cnt_d   = r_cnt_q - 1'b1;
            end
            ST_WRITE: begin
                if (r_cnt_q == '0) w_state_d = ST_WHOLD;
                else               w_cnt_d   = r_cnt_q - 1'b1;
            end
            ST_WHOLD: w_state_d = ST_DONE;
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // Pins decoded from registered state and latched payload only
    always_comb begin
        o_ram_ce_n = c_IDLE_CE_N;
        o_ram_oe_n = c_IDLE_OE_N;
        o_ram_we_n = c_IDLE_WE_N;
        o_ram_be_n = c_IDLE_BE_N;
        w_drive    = 1'b0;
        case (r_state_q)
            ST_READ: begin
                o_ram_ce_n = 1'b0;
                o_ram_oe_n = 1'b0;
            end
            ST_WRITE: begin
                o_ram_ce_n = 1'b0;
                o_ram_we_n = 1'b0;
                o_ram_be_n = ~i_sel;
                w_drive    = 1'b1;
            end
            // we_n has risen; keep chip, data and byte lanes for hold time
            ST_WHOLD: begin
                o_ram_ce_n = 1'b0;
                o_ram_be_n = ~i_sel;
                w_drive    = 1'b1;
            end
            default: ;
        endcase
    end

    assign io_ram_data = w_drive ? i_wdata : 32'bz;
    assign o_rdata     = io_ram_data;
    assign o_ram_addr  = i_addr;
    assign o_busy      = (r_state_q != ST_IDLE);
    assign o_done      = (r_state_q == ST_DONE);
    assign o_capture   = (r_state_q == ST_READ) && (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Fixed-priority arbiter (data over fetch) sharing one async SRAM
//            between the instruction-fetch and data ports.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 20,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [31:0]           p0_wdata,
    input  logic [3:0]            p0_sel,
    output logic [31:0]           p0_rdata,
    output logic                  p0_ack,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [31:0]           p1_wdata,
    input  logic [3:0]            p1_sel,
    output logic [31:0]           p1_rdata,
    output logic                  p1_ack,
    output logic                  owner,
    output logic                  busy,
    inout  wire  [31:0]           ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);

    logic                  w_busy, w_done, w_capture, w_start, w_start_we;
    logic [31:0]           w_rd_word;
    logic [ADDR_WIDTH-1:0] r_addr_q, w_addr_d;
    logic [31:0]           r_wdata_q, w_wdata_d;
    logic [3:0]            r_sel_q, w_sel_d;
    logic                  r_owner_q, w_owner_d;
    logic [31:0]           r_p0_rdata_q, w_p0_rdata_d;
    logic [31:0]           r_p1_rdata_q, w_p1_rdata_d;

    // Arbitrate in IDLE, latch the winner's payload, steer read data to the owner
    always_comb begin
        w_start      = !w_busy && (p0_req || p1_req);
        w_start_we   = p1_req ? p1_we : p0_we;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_sel_d      = r_sel_q;
        w_owner_d    = r_owner_q;
        w_p0_rdata_d = r_p0_rdata_q;
        w_p1_rdata_d = r_p1_rdata_q;
        if (w_start) begin
            if (p1_req) begin
                w_owner_d = PORT_DATA;
                w_addr_d  = p1_addr;
                w_wdata_d = p1_wdata;
                w_sel_d   = p1_sel;
            end else begin
                w_owner_d = PORT_INST;
                w_addr_d  = p0_addr;
                w_wdata_d = p0_wdata;
                w_sel_d   = p0_sel;
            end
        end
        if (w_capture) begin
            if (r_owner_q == PORT_DATA) w_p1_rdata_d = w_rd_word;
            else                        w_p0_rdata_d = w_rd_word;
        end
    end

    // Latched payload, owner and per-port read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_sel_q      <= '0;
            r_owner_q    <= PORT_INST;
            r_p0_rdata_q <= '0;
            r_p1_rdata_q <= '0;
        end else begin
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_sel_q      <= w_sel_d;
            r_owner_q    <= w_owner_d;
            r_p0_rdata_q <= w_p0_rdata_d;
            r_p1_rdata_q <= w_p1_rdata_d;
        end
    end

    sram_access_seq #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_CYCLES  (READ_CYCLES),
        .WRITE_CYCLES (WRITE_CYCLES)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_we        (w_start_we),
        .i_addr      (r_addr_q),
        .i_wdata     (r_wdata_q),
        .i_sel       (r_sel_q),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_capture   (w_capture),
        .o_rdata     (w_rd_word),
        .io_ram_data (ram_data),
        .o_ram_addr  (ram_addr),
        .o_ram_be_n  (ram_be_n),
        .o_ram_ce_n  (ram_ce_n),
        .o_ram_oe_n  (ram_oe_n),
        .o_ram_we_n  (ram_we_n)
    );

    assign busy     = w_busy;
    assign owner    = r_owner_q;
    assign p0_ack   = w_done && (r_owner_q == PORT_INST);
    assign p1_ack   = w_done && (r_owner_q == PORT_DATA);
    assign p0_rdata = r_p0_rdata_q;
    assign p1_rdata = r_p1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Scoreboard bench for sram_port_arbiter. Instance 0 uses 2/2
//            read/write cycles, instance 1 uses 1/3. Each has an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    typedef struct {
        int          ack_cyc;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst      [2];
    logic        p0_req   [2], p1_req  [2], p0_we [2], p1_we [2];
    logic [19:0] p0_addr  [2], p1_addr [2];
    logic [31:0] p0_wdata [2], p1_wdata[2];
    logic [3:0]  p0_sel   [2], p1_sel  [2];
    logic [31:0] p0_rdata [2], p1_rdata[2];
    logic        p0_ack   [2], p1_ack  [2], owner[2], busy[2];
    logic [19:0] ram_addr [2];
    logic [3:0]  ram_be_n [2];
    logic        ram_ce_n [2], ram_oe_n[2], ram_we_n[2];

    logic [31:0] mem     [2][256];
    logic [31:0] last_rd [2][2];
    exp_t        sbq     [4][$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          oe_run [2], we_run[2];
    logic [3:0]  last_be[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int RC = (gi == 0) ? 2 : 1;
        localparam int WC = (gi == 0) ? 2 : 3;
        wire [31:0] bus;

        assign bus = (!ram_ce_n[gi] && !ram_oe_n[gi]) ? mem[gi][ram_addr[gi][7:0]] : 32'bz;

        always @(posedge clk) begin
            if (!ram_ce_n[gi] && !ram_we_n[gi])
                for (int b = 0; b < 4; b++)
                    if (!ram_be_n[gi][b]) mem[gi][ram_addr[gi][7:0]][b*8 +: 8] = bus[b*8 +: 8];
        end

        sram_port_arbiter #(
            .ADDR_WIDTH(20), .READ_CYCLES(RC), .WRITE_CYCLES(WC)
        ) u_dut (
            .clk(clk), .rst(rst[gi]),
            .p0_req(p0_req[gi]), .p0_we(p0_we[gi]), .p0_addr(p0_addr[gi]),
            .p0_wdata(p0_wdata[gi]), .p0_sel(p0_sel[gi]), .p0_rdata(p0_rdata[gi]), .p0_ack(p0_ack[gi]),
            .p1_req(p1_req[gi]), .p1_we(p1_we[gi]), .p1_addr(p1_addr[gi]),
            .p1_wdata(p1_wdata[gi]), .p1_sel(p1_sel[gi]), .p1_rdata(p1_rdata[gi]), .p1_ack(p1_ack[gi]),
            .owner(owner[gi]), .busy(busy[gi]),
            .ram_data(bus), .ram_addr(ram_addr[gi]), .ram_be_n(ram_be_n[gi]),
            .ram_ce_n(ram_ce_n[gi]), .ram_oe_n(ram_oe_n[gi]), .ram_we_n(ram_we_n[gi])
        );
    end

    // Hand-computed pin timing per instance
    function automatic int rc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int wc(input int i);
        return (i == 0) ? 2 : 3;
    endfunction
    // Edges from sampling edge to the ack (DONE) cycle
    function automatic int lat(input int i, input logic we);
        return we ? wc(i) + 1 : rc(i);
    endfunction
    function automatic logic ack_of(input int i, input int p);
        return (p == 1) ? p1_ack[i] : p0_ack[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pin-protocol checks and scoreboard pops on each ack
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                oe_run[i] = 0;
                we_run[i] = 0;
            end else begin
                if (!ram_oe_n[i]) begin
                    oe_run[i]++;
                    chk($sformatf("read_pins%0d", i), {30'd0, ram_ce_n[i], ram_we_n[i]}, 32'd1);
                end else if (oe_run[i] != 0) begin
                    chk($sformatf("oe_len%0d", i), oe_run[i], rc(i));
                    oe_run[i] = 0;
                end
                if (!ram_we_n[i]) begin
                    we_run[i]++;
                    last_be[i] = ram_be_n[i];
                end else if (we_run[i] != 0) begin
                    chk($sformatf("we_len%0d", i), we_run[i], wc(i));
                    chk($sformatf("whold_ce%0d", i), {31'd0, ram_ce_n[i]}, 32'd0);
                    we_run[i] = 0;
                end
                for (int p = 0; p < 2; p++) begin
                    if (ack_of(i, p)) begin
                        if (sbq[i*2+p].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ack inst=%0d port=%0d actual=1 required=0", i, p);
                        end else begin
                            exp_t e;
                            e = sbq[i*2+p].pop_front();
                            chk($sformatf("ack_cyc%0d_%0d", i, p), cyc, e.ack_cyc);
                            chk($sformatf("owner%0d_%0d", i, p), {31'd0, owner[i]}, p);
                            chk($sformatf("rdata%0d_%0d", i, p), (p == 1) ? p1_rdata[i] : p0_rdata[i], e.rdata);
                            if (e.we) chk($sformatf("be_n%0d_%0d", i, p), {28'd0, last_be[i]}, {28'd0, ~e.sel});
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input int i, input int p, input logic we, input logic [19:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (p == 1) begin
            p1_req[i] = 1'b1; p1_we[i] = we; p1_addr[i] = a; p1_wdata[i] = d; p1_sel[i] = s;
        end else begin
            p0_req[i] = 1'b1; p0_we[i] = we; p0_addr[i] = a; p0_wdata[i] = d; p0_sel[i] = s;
        end
    endtask

    task automatic push_exp(input int i, input int p, input int ack_cyc, input logic we, input logic [3:0] s);
        exp_t e;
        e.ack_cyc = ack_cyc;
        e.we      = we;
        e.sel     = s;
        e.rdata   = last_rd[i][p];
        sbq[i*2+p].push_back(e);
    endtask

    // Hold request until ack, bounded, then release it
    task automatic wait_ack(input int i, input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_of(i, p) && n < 60);
        if (!ack_of(i, p)) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout inst=%0d port=%0d actual=0 required=1", i, p);
        end
        if (p == 1) p1_req[i] = 1'b0;
        else        p0_req[i] = 1'b0;
    endtask

    task automatic txn(input int i, input int p, input logic we, input logic [19:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [31:0] rd);
        @(negedge clk);
        drive(i, p, we, a, d, s);
        if (!we) last_rd[i][p] = rd;
        push_exp(i, p, cyc + 1 + lat(i, we), we, s);
        wait_ack(i, p);
    endtask

    initial begin
        int e0;
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 256; a++) mem[i][a] = 32'd0;
            rst[i] = 1'b1;
            p0_req[i] = 0; p0_we[i] = 0; p0_addr[i] = 0; p0_wdata[i] = 0; p0_sel[i] = 0;
            p1_req[i] = 0; p1_we[i] = 0; p1_addr[i] = 0; p1_wdata[i] = 0; p1_sel[i] = 0;
            last_rd[i][0] = 0; last_rd[i][1] = 0;
        end
        mem[0][8'h10] = 32'h12345678;
        mem[0][8'h20] = 32'h11223344;
        mem[0][8'h30] = 32'hCAFEF00D;
        mem[1][8'h10] = 32'h0BADBEEF;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_owner", {31'd0, owner[i]}, 0);
            chk("rst_busy", {31'd0, busy[i]}, 0);
            chk("rst_acks", {30'd0, p0_ack[i], p1_ack[i]}, 0);
            chk("rst_p0_rdata", p0_rdata[i], 0);
            chk("rst_p1_rdata", p1_rdata[i], 0);
            chk("rst_addr", {12'd0, ram_addr[i]}, 0);
            chk("rst_ctl_n", {29'd0, ram_ce_n[i], ram_oe_n[i], ram_we_n[i]}, 32'd7);
            chk("rst_be_n", {28'd0, ram_be_n[i]}, 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Single read on fetch port
        txn(0, 0, 1'b0, 20'h00010, 32'd0, 4'h0, 32'h12345678);
        // Data read, byte-lane write (rdata must stay), readback
        txn(0, 1, 1'b0, 20'h00020, 32'd0, 4'h0, 32'h11223344);
        txn(0, 1, 1'b1, 20'h00020, 32'hAABBCCDD, 4'b0010, 32'd0);
        txn(0, 1, 1'b0, 20'h00020, 32'd0, 4'h0, 32'h1122CC44);

        // Collision: data wins, fetch served after DONE + one IDLE
        @(negedge clk);
        drive(0, 1, 1'b0, 20'h00030, 32'd0, 4'h0);
        drive(0, 0, 1'b0, 20'h00010, 32'd0, 4'h0);
        e0 = cyc + 1;
        last_rd[0][1] = 32'hCAFEF00D;
        last_rd[0][0] = 32'h12345678;
        push_exp(0, 1, e0 + 2, 1'b0, 4'h0);
        push_exp(0, 0, e0 + 6, 1'b0, 4'h0);
        fork
            wait_ack(0, 1);
            wait_ack(0, 0);
        join

        // Turnaround: write then immediate read of the same word
        txn(0, 1, 1'b1, 20'h00040, 32'h55667788, 4'hF, 32'd0);
        txn(0, 0, 1'b0, 20'h00040, 32'd0, 4'h0, 32'h55667788);

        // Reset during the second WRITE cycle
        @(negedge clk);
        drive(0, 1, 1'b1, 20'h00050, 32'h99999999, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        p1_req[0] = 1'b0;
        @(negedge clk);
        chk("midrst_ctl_n", {29'd0, ram_ce_n[0], ram_oe_n[0], ram_we_n[0]}, 32'd7);
        chk("midrst_be_n", {28'd0, ram_be_n[0]}, 0);
        chk("midrst_busy", {31'd0, busy[0]}, 0);
        chk("midrst_acks", {30'd0, p0_ack[0], p1_ack[0]}, 0);
        chk("midrst_p1_rdata", p1_rdata[0], 0);
        rst[0] = 1'b0;
        last_rd[0][0] = 0;
        last_rd[0][1] = 0;
        txn(0, 0, 1'b0, 20'h00010, 32'd0, 4'h0, 32'h12345678);

        // Instance 1: READ_CYCLES=1, WRITE_CYCLES=3
        txn(1, 0, 1'b0, 20'h00010, 32'd0, 4'h0, 32'h0BADBEEF);
        txn(1, 1, 1'b1, 20'h00060, 32'hDEADBEEF, 4'hF, 32'd0);
        txn(1, 0, 1'b0, 20'h00060, 32'd0, 4'h0, 32'hDEADBEEF);

        repeat (4) @(negedge clk);
        chk("sb_empty", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
